// File: rtl/regf_mem_arb_if.sv
// Bus bundle between NUM_REQ requesters, the round-robin arbiter and the
// memory port of a generated register file.
interface regf_mem_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  // Handshake: req_i[n] with address/wena/wdata held stable until gnt_o[n];
  // an access transfers in every cycle where req_i[n] & gnt_o[n]. Exactly one
  // cycle later rvalid_o[n] pulses with rdata_o/err_o (writes: ack + err only).
  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0]                 req_wena_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]                 gnt_o;
  logic [NUM_REQ-1:0]                 rvalid_o;
  logic [DATA_WIDTH-1:0]              rdata_o;
  logic                               err_o;
  logic                               mem_ena_o;
  logic [ADDR_WIDTH-1:0]              mem_addr_o;
  logic                               mem_wena_o;
  logic [DATA_WIDTH-1:0]              mem_wdata_o;
  logic [DATA_WIDTH-1:0]              mem_rdata_i;
  logic                               mem_err_i;
  logic [7:0]                         err_cnt_o;

  modport slave (
    input  req_i, req_addr_i, req_wena_i, req_wdata_i, mem_rdata_i, mem_err_i,
    output gnt_o, rvalid_o, rdata_o, err_o, mem_ena_o, mem_addr_o, mem_wena_o,
           mem_wdata_o, err_cnt_o
  );

  modport master (
    output req_i, req_addr_i, req_wena_i, req_wdata_i, mem_rdata_i, mem_err_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, mem_ena_o, mem_addr_o, mem_wena_o,
           mem_wdata_o, err_cnt_o
  );
endinterface

// File: rtl/regf_mem_arb.sv
// Round-robin arbiter sharing one regf memory port between NUM_REQ masters,
// routing the one-cycle-late response back and counting error responses.
module regf_mem_arb #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic           main_clk_i,
  input  logic           main_rst_an_i,
  regf_mem_arb_if.slave  bus
);

  localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW1 = PW + 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt_idx;
  logic [PW1-1:0]     cand;
  logic               found;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsel;
  logic               any_rsel;
  logic               err;
  logic [7:0]         err_cnt;

  // Search from ptr+1 upward with wrap; the first active request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr} + PW1'(k);
      if (cand >= PW1'(NUM_REQ)) begin
        cand = cand - PW1'(NUM_REQ);
      end
      if (!found && bus.req_i[cand[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
    if (!main_rst_an_i) begin
      found = 1'b0;
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      ptr     <= PTR_RST;
      rsel    <= '0;
      err_cnt <= '0;
    end else begin
      if (found) begin
        ptr <= gnt_idx;
      end
      rsel <= gnt;
      if (err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign any_rsel = |rsel;
  assign err      = bus.mem_err_i & any_rsel;

  assign bus.gnt_o       = gnt;
  assign bus.mem_ena_o   = found;
  assign bus.mem_addr_o  = found ? bus.req_addr_i[gnt_idx]  : '0;
  assign bus.mem_wena_o  = found ? bus.req_wena_i[gnt_idx]  : 1'b0;
  assign bus.mem_wdata_o = found ? bus.req_wdata_i[gnt_idx] : '0;

  // The response belongs to whoever was granted on the previous edge.
  assign bus.rvalid_o  = rsel;
  assign bus.rdata_o   = any_rsel ? bus.mem_rdata_i : '0;
  assign bus.err_o     = err;
  assign bus.err_cnt_o = err_cnt;

endmodule

// File: tb/tb_regf_mem_arb.sv
// Bench for regf_mem_arb with four requesters, a behavioural regf model and a
// per-cycle scoreboard of grants and responses.
module tb_regf_mem_arb;

  localparam int NR     = 4;
  localparam int AW     = 13;
  localparam int DW     = 32;
  localparam int QW     = 2 + 1 + 1 + DW;
  localparam int MAPPED = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]         req;
  logic [NR-1:0][AW-1:0] addr;
  logic [NR-1:0]         wena;
  logic [NR-1:0][DW-1:0] wdata;
  logic [NR-1:0]         last_gnt;
  logic [DW-1:0]         regs [MAPPED];
  logic [QW-1:0]         exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int m_ptr = NR - 1;
  int m_cnt = 0;

  regf_mem_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regf_mem_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .main_clk_i    (clk),
    .main_rst_an_i (rst_n),
    .bus           (bus)
  );

  assign bus.req_i       = req;
  assign bus.req_addr_i  = addr;
  assign bus.req_wena_i  = wena;
  assign bus.req_wdata_i = wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register file model: low MAPPED words exist, everything above errors.
  // When idle it drives junk so response gating is exercised.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAPPED; i++) begin
        regs[i] <= (i == 4) ? 32'hCAFE0001 : (32'hA5A50000 + DW'(i));
      end
      bus.mem_rdata_i <= $urandom;
      bus.mem_err_i   <= 1'($urandom_range(0, 1));
    end else if (bus.mem_ena_o) begin
      if (bus.mem_addr_o < AW'(MAPPED)) begin
        if (bus.mem_wena_o) regs[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;
        bus.mem_rdata_i <= bus.mem_wena_o ? '0 : regs[bus.mem_addr_o[7:0]];
        bus.mem_err_i   <= 1'b0;
      end else begin
        bus.mem_rdata_i <= '0;
        bus.mem_err_i   <= 1'b1;
      end
    end else begin
      bus.mem_rdata_i <= $urandom;
      bus.mem_err_i   <= 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: every cycle predict the grant from the driven requests and
  // queue the response that must come back one cycle later.
  always @(negedge clk) begin
    logic [NR-1:0] eg;
    logic [NR-1:0] exp_rv;
    logic [QW-1:0] e;
    logic [DW-1:0] exp_rd;
    int            gi;
    int            c;
    eg     = '0;
    exp_rv = '0;
    e      = '0;
    exp_rd = '0;
    gi     = -1;
    c      = 0;
    if (!rst_n) begin
      m_ptr = NR - 1;
      m_cnt = 0;
      exp_q.delete();
      check("rst_gnt", 64'(bus.gnt_o), 64'(0));
      check("rst_mem_ena", 64'(bus.mem_ena_o), 64'(0));
      check("rst_rvalid", 64'(bus.rvalid_o), 64'(0));
      check("rst_rdata", 64'(bus.rdata_o), 64'(0));
      check("rst_err", 64'(bus.err_o), 64'(0));
      check("rst_err_cnt", 64'(bus.err_cnt_o), 64'(0));
    end else begin
      check("err_cnt", 64'(bus.err_cnt_o), 64'(m_cnt));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_rv[e[QW-1 -: 2]] = 1'b1;
        check("rvalid", 64'(bus.rvalid_o), 64'(exp_rv));
        check("err", 64'(bus.err_o), 64'(e[DW]));
        if (e[DW+1]) check("rdata", 64'(bus.rdata_o), 64'(e[DW-1:0]));
        if (e[DW] && m_cnt < 255) m_cnt++;
      end else begin
        check("idle_rvalid", 64'(bus.rvalid_o), 64'(0));
        check("idle_rdata", 64'(bus.rdata_o), 64'(0));
        check("idle_err", 64'(bus.err_o), 64'(0));
      end
      for (int k = 1; k <= NR; k++) begin
        c = (m_ptr + k) % NR;
        if (gi < 0 && req[c]) gi = c;
      end
      if (gi >= 0) eg[gi] = 1'b1;
      check("gnt", 64'(bus.gnt_o), 64'(eg));
      check("mem_ena", 64'(bus.mem_ena_o), 64'(gi >= 0));
      if (gi >= 0) begin
        check("mem_addr", 64'(bus.mem_addr_o), 64'(addr[gi]));
        check("mem_wena", 64'(bus.mem_wena_o), 64'(wena[gi]));
        check("mem_wdata", 64'(bus.mem_wdata_o), 64'(wdata[gi]));
        if (addr[gi] < AW'(MAPPED) && !wena[gi]) exp_rd = regs[addr[gi][7:0]];
        exp_q.push_back({2'(gi), ~wena[gi], (addr[gi] >= AW'(MAPPED)), exp_rd});
        m_ptr = gi;
      end else begin
        check("mem_addr_idle", 64'(bus.mem_addr_o), 64'(0));
        check("mem_wena_idle", 64'(bus.mem_wena_o), 64'(0));
        check("mem_wdata_idle", 64'(bus.mem_wdata_o), 64'(0));
      end
    end
  end

  initial begin
    logic [NR-1:0] fair_tbl [6];
    fair_tbl = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    req   = '0;
    addr  = '0;
    wena  = '0;
    wdata = '0;
    #1 rst_n = 1'b0;

    // Reset holds grants off even with requests pending.
    req = 4'b0011;
    addr[0] = 13'h0020;
    addr[1] = 13'h0021;
    repeat (3) begin
      tick();
      #1;
      check("hold_gnt", 64'(bus.gnt_o), 64'(0));
      check("hold_mem_ena", 64'(bus.mem_ena_o), 64'(0));
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1 check("rr_after_rst", 64'(bus.gnt_o), 64'((i % 2 == 0) ? 4'b0001 : 4'b0010));
    end

    // Single read by requester 1.
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    addr[1] = 13'h0004;
    #1;
    check("rd_gnt", 64'(bus.gnt_o), 64'(4'b0010));
    check("rd_mem_addr", 64'(bus.mem_addr_o), 64'(13'h0004));
    tick();
    req = '0;
    #1;
    check("rd_rvalid", 64'(bus.rvalid_o), 64'(4'b0010));
    check("rd_rdata", 64'(bus.rdata_o), 64'(32'hCAFE0001));

    // Fairness among 0, 2, 3; then 1 joins right after a grant to 0.
    tick();
    req = 4'b1000;
    addr[3] = 13'h0003;
    #1 check("fair_pre", 64'(bus.gnt_o), 64'(4'b1000));
    tick();
    req = 4'b1101;
    addr[0] = 13'h0000;
    addr[2] = 13'h0002;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      #1 check("fair_gnt", 64'(bus.gnt_o), 64'(fair_tbl[i]));
    end
    tick();
    #1 check("fair_gnt0", 64'(bus.gnt_o), 64'(4'b0001));
    tick();
    req = 4'b1111;
    addr[1] = 13'h0001;
    #1 check("join_gnt", 64'(bus.gnt_o), 64'(4'b0010));
    tick();
    req = '0;

    // Write to an unmapped word, then saturate the error counter.
    tick();
    req = 4'b0001;
    wena[0] = 1'b1;
    addr[0] = 13'h1000;
    wdata[0] = 32'hDEAD0000;
    #1;
    check("werr_gnt", 64'(bus.gnt_o), 64'(4'b0001));
    check("werr_cnt0", 64'(bus.err_cnt_o), 64'(0));
    tick();
    req = '0;
    #1;
    check("werr_rvalid", 64'(bus.rvalid_o), 64'(4'b0001));
    check("werr_err", 64'(bus.err_o), 64'(1));
    tick();
    #1;
    check("werr_cnt1", 64'(bus.err_cnt_o), 64'(1));
    check("werr_single", 64'(bus.rvalid_o), 64'(0));
    tick();
    req = 4'b0001;
    repeat (299) tick();
    tick();
    req = '0;
    tick();
    tick();
    #1 check("err_cnt_sat", 64'(bus.err_cnt_o), 64'(255));

    // Back-to-back write then read of the same word.
    tick();
    req = 4'b0001;
    wena[0] = 1'b1;
    addr[0] = 13'h0010;
    wdata[0] = 32'h12345678;
    #1 check("b2b_wr_gnt", 64'(bus.gnt_o), 64'(4'b0001));
    tick();
    wena[0] = 1'b0;
    #1;
    check("b2b_rd_gnt", 64'(bus.gnt_o), 64'(4'b0001));
    check("b2b_wr_ack", 64'(bus.rvalid_o), 64'(4'b0001));
    tick();
    req = '0;
    #1;
    check("b2b_rd_rvalid", 64'(bus.rvalid_o), 64'(4'b0001));
    check("b2b_rd_rdata", 64'(bus.rdata_o), 64'(32'h12345678));

    // Reset right after a grant drops the response.
    tick();
    req = 4'b0010;
    addr[1] = 13'h0004;
    #1 check("rmid_gnt", 64'(bus.gnt_o), 64'(4'b0010));
    tick();
    rst_n = 1'b0;
    req = '0;
    #1 check("rmid_rvalid", 64'(bus.rvalid_o), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    req = 4'b0011;
    #1;
    check("rmid_rsel_clr", 64'(bus.rvalid_o), 64'(0));
    check("rmid_ptr_rst", 64'(bus.gnt_o), 64'(4'b0001));
    last_gnt = bus.gnt_o;

    // Random traffic obeying the hold-until-granted rule.
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      for (int n = 0; n < NR; n++) begin
        if (!req[n] || last_gnt[n]) begin
          req[n]   = ($urandom_range(0, 3) != 0);
          addr[n]  = AW'($urandom_range(0, 300));
          wena[n]  = 1'($urandom_range(0, 1));
          wdata[n] = $urandom;
        end
      end
      #1 last_gnt = bus.gnt_o;
    end
    tick();
    req = '0;
    tick();
    tick();
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regf_mem_arb.md
# regf_mem_arb

Round-robin arbiter that shares the single memory-mapped bus port of a generated register file (`mem_*`) between `NUM_REQ` bus masters. It sits directly in front of a `*_regf` instance, for example `corner_regf`. It grants at most one access per cycle and forwards it to the register file. The one-cycle-late read data and error response is routed back to the requester that issued the access. It also keeps a saturating count of error responses for debug.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `ADDR_WIDTH`, default 13: word address width, matches `mem_addr_i` of the regf.
- `DATA_WIDTH`, default 32: data width, matches `mem_wdata_i` / `mem_rdata_o` of the regf.

Ports:
- `main_clk_i` input 1: clock.
- `main_rst_an_i` input 1: asynchronous reset, active-low.
- `req_i` input `NUM_REQ`: per-requester access request.
- `req_addr_i` input `NUM_REQ` x `ADDR_WIDTH`: per-requester address.
- `req_wena_i` input `NUM_REQ`: per-requester write enable (1 = write, 0 = read).
- `req_wdata_i` input `NUM_REQ` x `DATA_WIDTH`: per-requester write data.
- `gnt_o` output `NUM_REQ`: one-hot grant; the access is accepted in this cycle.
- `rvalid_o` output `NUM_REQ`: one-hot response strobe.
- `rdata_o` output `DATA_WIDTH`: response read data, shared by all requesters.
- `err_o` output 1: response error, qualified by `rvalid_o`.
- `mem_ena_o` output 1: to regf `mem_ena_i`.
- `mem_addr_o` output `ADDR_WIDTH`: to regf `mem_addr_i`.
- `mem_wena_o` output 1: to regf `mem_wena_i`.
- `mem_wdata_o` output `DATA_WIDTH`: to regf `mem_wdata_i`.
- `mem_rdata_i` input `DATA_WIDTH`: from regf `mem_rdata_o`.
- `mem_err_i` input 1: from regf `mem_err_o`.
- `err_cnt_o` output 8: saturating count of error responses.

## Operation

**Requester protocol**
- A requester raises `req_i[n]` and holds address, write enable and write data stable until `gnt_o[n]` is high.
- The transfer completes in the grant cycle.
- A requester may keep `req_i[n]` high to issue back-to-back accesses. Each grant cycle is one access.

**Arbitration**
- Arbitration is combinational and round-robin.
- Register `ptr` holds the index of the last granted requester. Reset value is `NUM_REQ-1`, so requester 0 wins the first contention.
- The search starts at `ptr+1` and wraps modulo `NUM_REQ`. The first requester found with `req_i` high is granted.
- `ptr` updates to the granted index only in cycles with a grant. Idle cycles leave it unchanged.

**Memory side**
- `mem_ena_o = |gnt_o`.
- `mem_addr_o`, `mem_wena_o` and `mem_wdata_o` are muxed from the granted requester.
- With no grant: `mem_addr_o`, `mem_wena_o` and `mem_wdata_o` are 0.

**Response routing**
- Register `rsel` (one-hot, `NUM_REQ` bits) captures `gnt_o` each cycle. Reset value is 0.
- `rvalid_o = rsel`.
- `rdata_o = mem_rdata_i` when `|rsel`, else 0.
- `err_o = mem_err_i & |rsel`.
- Writes also produce an `rvalid_o` pulse. It acts as the write acknowledge, with `err_o` meaningful and `rdata_o` don't-care.

**Error counter**
- `err_cnt_o` increments by 1 on each cycle with `err_o` = 1.
- It saturates at 255 and never wraps.

**Reset**
- While `main_rst_an_i` is low, `gnt_o` and `mem_ena_o` are forced to 0 regardless of `req_i`.
- `ptr` resets to `NUM_REQ-1`; `rsel` and `err_cnt_o` reset to 0.
- So after reset: `gnt_o`, `rvalid_o`, `mem_ena_o`, `err_o`, `rdata_o` and `err_cnt_o` are all 0.
- Reset asserted in the cycle after a grant drops that response: `rsel` clears immediately and no `rvalid_o` pulse appears. The requester must reissue the access.

## Timing

- Request to grant: 0 cycles. `gnt_o` is combinational from `req_i` and `ptr`.
- Grant to response: exactly 1 cycle. The regf samples on the grant edge and drives `mem_rdata_i` / `mem_err_i` in the next cycle.
- Throughput: one access per cycle, sustained.
- Grant in cycle t+1 overlaps the response to the grant in cycle t. `rvalid_o` and `gnt_o` may be high together, for the same or different requesters.
- Fairness: with all requesters continuously requesting, each is granted exactly once every `NUM_REQ` cycles.
- No combinational path from `mem_rdata_i` or `mem_err_i` to `gnt_o`.

## Test plan

- **Reset values.** Hold reset with `req_i`=2'b11 → `gnt_o`=0 and `mem_ena_o`=0. Release reset with `req_i`=2'b11 still high → first `gnt_o`=2'b01, then 2'b10, 2'b01 alternating.
- **Single read.** Requester 1 reads address 13'h0004 with regf returning 32'hCAFE0001 → `gnt_o`=2'b10 and `mem_addr_o`=13'h0004 in cycle t; `rvalid_o`=2'b10 and `rdata_o`=32'hCAFE0001 in cycle t+1.
- **Fairness, `NUM_REQ`=4.** Requesters 0, 2 and 3 request continuously → grant order 0,2,3,0,2,3. Then requester 1 joins after a grant to 0 → it is granted in the next cycle.
- **Write error.** Write to an unmapped address with regf `mem_err_i`=1 → one `rvalid_o` pulse with `err_o`=1 and `err_cnt_o` 0→1. Repeat 300 errors → `err_cnt_o` holds at 255.
- **Back-to-back, mixed.** Requester 0 writes 32'h12345678 to 13'h0010 and then immediately reads 13'h0010 → grants in consecutive cycles, and the read response returns 32'h12345678 two cycles after the write grant.
- **Reset mid-access.** Assert reset in the cycle after a grant → no `rvalid_o` pulse, and `rsel`=0 after reset release.
